sd_emmc_raid_cmd: RTL and testbench

SD_EMMC_RAID_CMD -- requirements
Module: sd_emmc_raid_cmd

---
 rtl/sd_emmc_raid_cmd.sv | 224 ++++++++++++++++++++++
 tb/tb_sd_emmc_raid_cmd.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sd_emmc_raid_cmd.sv
// ============================================================================
// Module : sd_emmc_raid_cmd -- issues one command to NUM_CH striped eMMC
// channels and merges their responses/status. Option macro: RAID_RESP_CMP_EN.
// Revision: 1.0
// ============================================================================
`default_nettype none

module sd_emmc_raid_cmd #(
  parameter int NUM_CH   = 2,
  parameter int TO_W     = 16,
  parameter int SHORT_TO = 120,
  parameter int LONG_TO  = 250,
  parameter int BUSY_TO  = 16'hFFFF
) (
  input  logic                    sd_clk,
  input  logic                    rst,
  input  logic                    start_i,
  input  logic                    int_status_rst_i,
  input  logic [NUM_CH-1:0]       ch_en_i,
  input  logic [31:0]             argument_i,
  input  logic [13:0]             command_i,
  input  logic [NUM_CH-1:0]       finish_i,
  input  logic [NUM_CH-1:0]       crc_ok_i,
  input  logic [NUM_CH-1:0]       index_ok_i,
  input  logic [NUM_CH-1:0]       busy_i,
  input  logic [NUM_CH*120-1:0]   response_i,
  output logic                    start_xfr_o,
  output logic                    go_idle_o,
  output logic [39:0]             cmd_o,
  output logic [1:0]              setting_o,
  output logic [31:0]             response_0_o,
  output logic [31:0]             response_1_o,
  output logic [31:0]             response_2_o,
  output logic [31:0]             response_3_o,
  output logic [5:0]              int_status_o,
  output logic [NUM_CH-1:0]       ch_err_o
);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    EXECUTE    = 2'd1,
    BUSY_CHECK = 2'd2,
    ABORT      = 2'd3
  } state_t;

  localparam logic [TO_W-1:0] SHORT_LIM = TO_W'(SHORT_TO);
  localparam logic [TO_W-1:0] LONG_LIM  = TO_W'(LONG_TO);
  localparam logic [TO_W-1:0] BUSY_LIM  = TO_W'(BUSY_TO);

  state_t            state;
  logic [NUM_CH-1:0] en, done;
  logic [TO_W-1:0]   wd, limit;
  logic [1:0]        rtype;
  logic              crc_chk, idx_chk;
  logic [5:0]        int_stat;

  logic [NUM_CH-1:0] fin, crc_bad, idx_bad, done_next, err_set, resp_mis;
  logic              all_done, abort_now;
  logic [5:0]        set_stat;
  logic [119:0]      low_resp;
  int                low;

  logic unused_cmd_bits;
  assign unused_cmd_bits = &{1'b0, command_i[7:5], command_i[2]};

  assign int_status_o = (state == IDLE) ? int_stat : 6'h00;

  always_comb begin
    fin       = finish_i & en & ~done;
    crc_bad   = crc_chk ? (fin & ~crc_ok_i) : '0;
    idx_bad   = idx_chk ? (fin & ~index_ok_i) : '0;
    done_next = done | fin;
    all_done  = &(done_next | ~en);
    low = 0;
    for (int k = NUM_CH - 1; k >= 0; k--)
      if (en[k]) low = k;
    low_resp = response_i[low*120 +: 120];
  end

`ifdef RAID_RESP_CMP_EN
  // Each channel's short response is held from its own finish until completion.
  logic [31:0] short_q   [NUM_CH];
  logic [31:0] short_now [NUM_CH];

  always_comb begin
    resp_mis = '0;
    for (int k = 0; k < NUM_CH; k++)
      short_now[k] = fin[k] ? response_i[k*120+88 +: 32] : short_q[k];
    for (int k = 0; k < NUM_CH; k++)
      if (state == EXECUTE && rtype[1] && en[k] && short_now[k] != short_now[low])
        resp_mis[k] = 1'b1;
  end

  always_ff @(posedge sd_clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < NUM_CH; k++) short_q[k] <= '0;
    end else if (state == EXECUTE) begin
      for (int k = 0; k < NUM_CH; k++)
        if (fin[k]) short_q[k] <= short_now[k];
    end
  end
`else
  assign resp_mis = '0;
`endif

  always_comb begin
    set_stat  = '0;
    err_set   = '0;
    abort_now = 1'b0;
    case (state)
      EXECUTE: begin
        err_set = crc_bad | idx_bad;
        if (|crc_bad) set_stat = set_stat | 6'h28;
        if (|idx_bad) set_stat = set_stat | 6'h30;
        // Completion wins over a timeout landing in the same cycle.
        if (all_done) begin
          err_set = err_set | resp_mis;
          if (|resp_mis) set_stat = set_stat | 6'h20;
          if (rtype != 2'b11) set_stat = set_stat | 6'h01;
        end else if (rtype != 2'b00 && wd >= limit) begin
          set_stat  = set_stat | 6'h24;
          err_set   = err_set | (en & ~done_next);
          abort_now = 1'b1;
        end
      end
      BUSY_CHECK: begin
        if ((busy_i & en) == '0) begin
          set_stat = 6'h03;
        end else if (wd >= BUSY_LIM) begin
          set_stat  = 6'h24;
          abort_now = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge sd_clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      en           <= '0;
      done         <= '0;
      wd           <= '0;
      limit        <= '0;
      rtype        <= '0;
      crc_chk      <= 1'b0;
      idx_chk      <= 1'b0;
      int_stat     <= '0;
      ch_err_o     <= '0;
      start_xfr_o  <= 1'b0;
      go_idle_o    <= 1'b0;
      cmd_o        <= '0;
      setting_o    <= '0;
      response_0_o <= '0;
      response_1_o <= '0;
      response_2_o <= '0;
      response_3_o <= '0;
    end else begin
      start_xfr_o <= 1'b0;
      go_idle_o   <= 1'b0;
      ch_err_o    <= ch_err_o | err_set;
      int_stat    <= int_status_rst_i ? 6'h00 : (int_stat | set_stat);
      case (state)
        IDLE: begin
          cmd_o     <= {2'b01, command_i[13:8], argument_i};
          setting_o <= {command_i[1:0] == 2'b01, command_i[1:0] != 2'b00};
          rtype     <= command_i[1:0];
          limit     <= (command_i[1:0] == 2'b01) ? LONG_LIM : SHORT_LIM;
          crc_chk   <= command_i[3];
          idx_chk   <= command_i[4];
          wd        <= '0;
          done      <= '0;
          if (start_i) begin
            en       <= ch_en_i;
            ch_err_o <= '0;
            if (ch_en_i == '0) begin
              if (!int_status_rst_i) int_stat <= 6'h21;
            end else begin
              int_stat    <= 6'h00;
              start_xfr_o <= 1'b1;
              state       <= EXECUTE;
            end
          end
        end
        EXECUTE: begin
          done <= done_next;
          if (rtype != 2'b00 && fin[low]) begin
            if (rtype == 2'b01) begin
              response_3_o <= {8'h00, low_resp[119:96]};
              response_2_o <= low_resp[95:64];
              response_1_o <= low_resp[63:32];
              response_0_o <= low_resp[31:0];
            end else begin
              response_0_o <= low_resp[119:88];
            end
          end
          if (all_done) begin
            wd    <= '0;
            state <= (rtype == 2'b11) ? BUSY_CHECK : IDLE;
          end else if (abort_now) begin
            go_idle_o <= 1'b1;
            state     <= ABORT;
          end else if (wd != '1) begin
            wd <= wd + 1'b1;
          end
        end
        BUSY_CHECK: begin
          if (set_stat[1]) begin
            state <= IDLE;
          end else if (abort_now) begin
            go_idle_o <= 1'b1;
            state     <= ABORT;
          end else if (wd != '1) begin
            wd <= wd + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_sd_emmc_raid_cmd.sv
// ============================================================================
// Module : tb_sd_emmc_raid_cmd -- scoreboard bench for sd_emmc_raid_cmd.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_sd_emmc_raid_cmd;
  localparam int NUM_CH   = 2;
  localparam int SHORT_TO = 120;
  localparam int LONG_TO  = 250;
  localparam int NEVER    = -1;

  logic                  sd_clk = 1'b0;
  logic                  rst = 1'b1;
  logic                  start_i = 1'b0;
  logic                  int_status_rst_i = 1'b0;
  logic [NUM_CH-1:0]     ch_en_i = '0;
  logic [31:0]           argument_i = '0;
  logic [13:0]           command_i = '0;
  logic [NUM_CH-1:0]     finish_i = '0;
  logic [NUM_CH-1:0]     crc_ok_i = '0;
  logic [NUM_CH-1:0]     index_ok_i = '0;
  logic [NUM_CH-1:0]     busy_i = '0;
  logic [NUM_CH*120-1:0] response_i = '0;
  logic                  start_xfr_o, go_idle_o;
  logic [39:0]           cmd_o;
  logic [1:0]            setting_o;
  logic [31:0]           response_0_o, response_1_o, response_2_o, response_3_o;
  logic [5:0]            int_status_o;
  logic [NUM_CH-1:0]     ch_err_o;

  always #5 sd_clk = ~sd_clk;

  sd_emmc_raid_cmd #(.NUM_CH(NUM_CH), .TO_W(16), .SHORT_TO(SHORT_TO),
                     .LONG_TO(LONG_TO), .BUSY_TO(16'hFFFF)) dut (
    .sd_clk(sd_clk), .rst(rst), .start_i(start_i), .int_status_rst_i(int_status_rst_i),
    .ch_en_i(ch_en_i), .argument_i(argument_i), .command_i(command_i),
    .finish_i(finish_i), .crc_ok_i(crc_ok_i), .index_ok_i(index_ok_i), .busy_i(busy_i),
    .response_i(response_i), .start_xfr_o(start_xfr_o), .go_idle_o(go_idle_o),
    .cmd_o(cmd_o), .setting_o(setting_o), .response_0_o(response_0_o),
    .response_1_o(response_1_o), .response_2_o(response_2_o), .response_3_o(response_3_o),
    .int_status_o(int_status_o), .ch_err_o(ch_err_o));

  typedef struct {
    logic [5:0]        st;
    logic [NUM_CH-1:0] err;
    logic [31:0]       r0, r1, r2, r3;
    logic [39:0]       cmd;
    logic [1:0]        set;
    int                n_go;
    int                n_xfr;
  } exp_t;

  exp_t         sb[$];
  int           vectors = 0;
  int           miscompares = 0;
  logic [31:0]  m_resp [4];
  int           st_fin  [NUM_CH];
  bit           st_crc  [NUM_CH];
  bit           st_idx  [NUM_CH];
  int           st_busy [NUM_CH];
  logic [119:0] st_resp [NUM_CH];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: a command ends when int_status_o rises from zero.
  initial begin : monitor
    logic [5:0] prev;
    int go_cnt, xfr_cnt;
    exp_t e;
    prev = 0; go_cnt = 0; xfr_cnt = 0;
    forever begin
      @(negedge sd_clk);
      if (rst) begin
        prev = 0; go_cnt = 0; xfr_cnt = 0;
      end else begin
        if (go_idle_o) go_cnt++;
        if (start_xfr_o) xfr_cnt++;
        if (prev == 0 && int_status_o != 0) begin
          if (sb.size() == 0) begin
            check("unexpected_completion", int_status_o, 0);
          end else begin
            e = sb.pop_front();
            check("int_status", int_status_o, e.st);
            check("ch_err", ch_err_o, e.err);
            check("response_0", response_0_o, e.r0);
            check("response_1", response_1_o, e.r1);
            check("response_2", response_2_o, e.r2);
            check("response_3", response_3_o, e.r3);
            check("cmd", cmd_o, e.cmd);
            check("setting", setting_o, e.set);
            check("go_idle_pulses", go_cnt, e.n_go);
            check("start_xfr_pulses", xfr_cnt, e.n_xfr);
          end
          go_cnt = 0; xfr_cnt = 0;
        end
        prev = int_status_o;
      end
    end
  end

  task automatic stim(input int f0, input int f1, input bit c0, input bit c1,
                      input bit i0, input bit i1, input int b0, input int b1, input bit same);
    st_fin[0] = f0;  st_fin[1] = f1;
    st_crc[0] = c0;  st_crc[1] = c1;
    st_idx[0] = i0;  st_idx[1] = i1;
    st_busy[0] = b0; st_busy[1] = b1;
    for (int k = 0; k < NUM_CH; k++)
      st_resp[k] = 120'({$urandom, $urandom, $urandom, $urandom});
    if (same) st_resp[1][119:88] = st_resp[0][119:88];
  endtask

  task automatic run_cmd(input logic [1:0] typ, input logic [NUM_CH-1:0] en,
                         input bit crc_c, input bit idx_c);
    exp_t e;
    int limit, low;
    bit tout, got;
    bit fin_ok [NUM_CH];
    logic [13:0] cmd;
    logic [31:0] arg;
    cmd = {6'($urandom), 3'($urandom), idx_c, crc_c, 1'($urandom), typ};
    arg = $urandom;
    limit = (typ == 2'b01) ? LONG_TO : SHORT_TO;
    e.cmd = {2'b01, cmd[13:8], arg};
    e.set = {typ == 2'b01, typ != 2'b00};
    e.n_xfr = (en != 0) ? 1 : 0;
    e.n_go = 0; e.st = 0; e.err = 0;
    if (en == 0) begin
      e.st = 6'h21;
    end else begin
      low = -1; tout = 0;
      for (int k = 0; k < NUM_CH; k++) begin
        fin_ok[k] = en[k] && st_fin[k] >= 0 && (typ == 2'b00 || st_fin[k] <= limit);
        if (en[k] && !fin_ok[k]) tout = 1;
        if (en[k] && low < 0) low = k;
        if (fin_ok[k] && crc_c && !st_crc[k]) begin e.st |= 6'h28; e.err[k] = 1'b1; end
        if (fin_ok[k] && idx_c && !st_idx[k]) begin e.st |= 6'h30; e.err[k] = 1'b1; end
      end
      if (fin_ok[low] && typ[1]) m_resp[0] = st_resp[low][119:88];
      if (fin_ok[low] && typ == 2'b01) begin
        m_resp[3] = {8'h00, st_resp[low][119:96]};
        m_resp[2] = st_resp[low][95:64];
        m_resp[1] = st_resp[low][63:32];
        m_resp[0] = st_resp[low][31:0];
      end
      if (tout) begin
        e.st |= 6'h24;
        e.n_go = 1;
        for (int k = 0; k < NUM_CH; k++)
          if (en[k] && !fin_ok[k]) e.err[k] = 1'b1;
      end else begin
`ifdef RAID_RESP_CMP_EN
        if (typ[1])
          for (int k = 0; k < NUM_CH; k++)
            if (en[k] && st_resp[k][119:88] != st_resp[low][119:88]) begin
              e.err[k] = 1'b1; e.st |= 6'h20;
            end
`endif
        e.st |= (typ == 2'b11) ? 6'h03 : 6'h01;
      end
    end
    e.r0 = m_resp[0]; e.r1 = m_resp[1]; e.r2 = m_resp[2]; e.r3 = m_resp[3];

    @(posedge sd_clk); #1;
    int_status_rst_i = 1'b1;
    @(posedge sd_clk); #1;
    int_status_rst_i = 1'b0;
    check("status_cleared", int_status_o, 0);
    command_i = cmd; argument_i = arg; ch_en_i = en; start_i = 1'b1;
    for (int k = 0; k < NUM_CH; k++) response_i[k*120 +: 120] = st_resp[k];
    sb.push_back(e);
    @(posedge sd_clk); #1;
    start_i = 1'b0;
    command_i = 14'($urandom); argument_i = $urandom; ch_en_i = NUM_CH'($urandom);
    got = 0;
    for (int c = 0; c < 600; c++) begin
      for (int k = 0; k < NUM_CH; k++) begin
        finish_i[k]   = en[k] ? (st_fin[k] == c) : 1'b1;
        crc_ok_i[k]   = en[k] ? st_crc[k] : 1'b0;
        index_ok_i[k] = en[k] ? st_idx[k] : 1'b0;
        busy_i[k]     = (c < st_busy[k]);
      end
      @(posedge sd_clk); #1;
      if (int_status_o != 0) begin got = 1; break; end
    end
    finish_i = '0; busy_i = '0;
    if (!got) check("completion_within_budget", 0, 1);
  endtask

  task automatic clear_beats_set();
    @(posedge sd_clk); #1;
    ch_en_i = '0; start_i = 1'b1; int_status_rst_i = 1'b1;
    @(posedge sd_clk); #1;
    start_i = 1'b0; int_status_rst_i = 1'b0;
    check("clear_beats_set_status", int_status_o, 0);
    check("clear_beats_set_xfr", start_xfr_o, 0);
  endtask

  task automatic reset_test();
    @(posedge sd_clk); #1;
    command_i = {6'd17, 3'b000, 1'b1, 1'b1, 1'b0, 2'b10};
    argument_i = 32'hA5A5_0001; ch_en_i = '1; start_i = 1'b1;
    @(posedge sd_clk); #1;
    start_i = 1'b0;
    repeat (4) @(posedge sd_clk);
    #3 rst = 1'b1;
    #1;
    check("rst_cmd", cmd_o, 0);
    check("rst_setting", setting_o, 0);
    check("rst_resp0", response_0_o, 0);
    check("rst_resp3", response_3_o, 0);
    check("rst_go_idle", go_idle_o, 0);
    check("rst_int_status", int_status_o, 0);
    check("rst_ch_err", ch_err_o, 0);
    @(posedge sd_clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 4; i++) m_resp[i] = '0;
  endtask

  initial begin : watchdog
    #5_000_000;
    $display("FAIL global_timeout: got no end, expected summary");
    $fatal(1, "simulation time limit");
  end

  initial begin : driver
    logic [1:0] typ;
    logic [NUM_CH-1:0] en;
    for (int i = 0; i < 4; i++) m_resp[i] = '0;
    repeat (3) @(posedge sd_clk);
    #1;
    check("reset_start_xfr", start_xfr_o, 0);
    check("reset_cmd", cmd_o, 0);
    check("reset_int_status", int_status_o, 0);
    check("reset_ch_err", ch_err_o, 0);
    rst = 1'b0;

    stim(3, 3, 1, 1, 1, 1, 0, 0, 1);                 run_cmd(2'b10, 2'b11, 1, 1);
    stim(2, 7, 1, 0, 1, 1, 0, 0, 1);                 run_cmd(2'b10, 2'b11, 1, 0);
    stim(4, NEVER, 1, 1, 1, 1, 0, 0, 1);             run_cmd(2'b01, 2'b11, 1, 1);
    stim(1, 1, 1, 1, 1, 1, 0, 12, 1);                run_cmd(2'b11, 2'b11, 0, 0);
    stim(0, SHORT_TO, 1, 1, 1, 1, 0, 0, 1);          run_cmd(2'b10, 2'b11, 0, 0);
    stim(0, SHORT_TO + 1, 1, 1, 1, 1, 0, 0, 1);      run_cmd(2'b10, 2'b11, 0, 0);
    stim(5, 5, 1, 1, 1, 1, 0, 0, 1);                 run_cmd(2'b10, 2'b00, 1, 1);
    stim(6, 2, 1, 1, 1, 1, 0, 0, 0);                 run_cmd(2'b00, 2'b11, 1, 1);
    stim(NEVER, 3, 1, 1, 1, 1, 1000, 0, 0);          run_cmd(2'b01, 2'b10, 1, 1);
    stim(2, 4, 1, 0, 0, 1, 0, 0, 1);                 run_cmd(2'b01, 2'b11, 1, 1);
`ifdef RAID_RESP_CMP_EN
    stim(2, 2, 1, 1, 1, 1, 0, 0, 0);
    st_resp[0][119:88] = 32'h0000_0900;
    st_resp[1][119:88] = 32'h0000_0700;
    run_cmd(2'b10, 2'b11, 0, 0);
`endif
    clear_beats_set();
    reset_test();

    for (int n = 0; n < 40; n++) begin
      typ = 2'($urandom);
      en  = ($urandom_range(0, 7) == 0) ? '0 : NUM_CH'($urandom_range(1, (1 << NUM_CH) - 1));
      for (int k = 0; k < NUM_CH; k++) begin
        st_fin[k]  = ($urandom_range(0, 9) == 0 && typ != 2'b00) ? NEVER : int'($urandom_range(0, 30));
        st_crc[k]  = ($urandom_range(0, 4) != 0);
        st_idx[k]  = ($urandom_range(0, 4) != 0);
        st_busy[k] = en[k] ? int'($urandom_range(0, 60)) : 1000;
        st_resp[k] = 120'({$urandom, $urandom, $urandom, $urandom});
      end
      if ($urandom_range(0, 1) == 1) st_resp[1][119:88] = st_resp[0][119:88];
      run_cmd(typ, en, 1'($urandom), 1'($urandom));
    end

    repeat (3) @(posedge sd_clk);
    #1;
    check("scoreboard_drained", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
